// File: rtl/waterfall_pkg.sv
// rtl/waterfall_pkg.sv - shared types and helpers for the waterfall row store
package waterfall_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_PEAK = 2'd1,
        MODE_AVG  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    function automatic logic [2:0] clamp_log2(input logic [2:0] v, input int unsigned max_log2);
        return (32'(v) > max_log2) ? 3'(max_log2) : v;
    endfunction

    // Pass and reserved modes always commit every frame on its own.
    function automatic logic [2:0] group_log2(input mode_e m, input logic [2:0] v,
                                              input int unsigned max_log2);
        return (m == MODE_PEAK || m == MODE_AVG) ? clamp_log2(v, max_log2) : 3'd0;
    endfunction

endpackage

// File: rtl/waterfall_accum_buffer_if.sv
// rtl/waterfall_accum_buffer_if.sv - sample stream and row read-out bundle
interface waterfall_accum_buffer_if #(
    parameter int DW = 8,
    parameter int BW = 9,
    parameter int RW = 9
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          rd_en;
    logic [BW-1:0] rd_bin;
    logic [RW-1:0] rd_row;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    modport master (output in_data, in_valid, in_last, rd_en, rd_bin, rd_row,
                    input  rd_data, rd_valid);
    modport slave  (input  in_data, in_valid, in_last, rd_en, rd_bin, rd_row,
                    output rd_data, rd_valid);
endinterface

// File: rtl/waterfall_accum_line.sv
// rtl/waterfall_accum_line.sv - per-bin accumulator, async read / sync write
module waterfall_accum_line #(
    parameter int BINS = 512,
    parameter int AW   = 11,
    parameter int BW   = $clog2(BINS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [BW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [BW-1:0] raddr,
    output logic [AW-1:0] rdata
);
    logic [AW-1:0] mem [BINS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/waterfall_accum_buffer.sv
// rtl/waterfall_accum_buffer.sv - frame combiner feeding a circular spectrogram row store
module waterfall_accum_buffer
    import waterfall_pkg::*;
#(
    parameter int BINS         = 512,
    parameter int HEIGHT       = 300,
    parameter int DW           = 8,
    parameter int AVG_MAX_LOG2 = 3,
    parameter int BW           = $clog2(BINS),
    parameter int RW           = $clog2(HEIGHT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    waterfall_accum_buffer_if.slave  bus,
    input  logic [1:0]               mode,
    input  logic [2:0]               avg_log2,
    input  logic                     freeze,
    output logic                     row_done,
    output logic [RW:0]              fill,
    output logic                     overflow
);
    localparam int AW = DW + AVG_MAX_LOG2;
    localparam int KW = (AVG_MAX_LOG2 > 0) ? AVG_MAX_LOG2 : 1;

    logic [BW-1:0]    bin_q, bin_d;
    logic [KW-1:0]    k_q, k_d;
    logic             in_frame_q, in_frame_d;
    logic             drop_q, drop_d;
    mode_e            grp_mode_q, grp_mode_d;
    logic [2:0]       grp_log2_q, grp_log2_d;
    logic [RW-1:0]    wr_row_q, wr_row_d;
    logic [RW:0]      fill_q, fill_d;
    logic             row_done_q, row_done_d;
    logic             overflow_q, overflow_d;
    logic             rd_stage_q, rd_stage_d;
    logic             rd_zero_q, rd_zero_d;
    logic [RW+BW-1:0] rd_addr_q, rd_addr_d;
    logic             rd_valid_q, rd_valid_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;

    logic             frame_start, drop_cur, grp_start, final_frame, beat, acc_we, ram_we;
    mode_e            cur_mode;
    logic [2:0]       cur_log2;
    logic [AW-1:0]    acc_rd, in_ext, combined;
    logic [DW-1:0]    result;
    logic [RW-1:0]    newest, row_addr;

    logic [DW-1:0]    row_mem [HEIGHT*BINS];

    waterfall_accum_line #(.BINS(BINS), .AW(AW), .BW(BW)) u_line (
        .clk   (clk),
        .we    (acc_we),
        .waddr (bin_q),
        .wdata (combined),
        .raddr (bin_q),
        .rdata (acc_rd)
    );

    // Freeze and group parameters are only sampled on the first beat of a frame/group.
    always_comb begin
        frame_start = !in_frame_q;
        drop_cur    = frame_start ? freeze : drop_q;
        grp_start   = frame_start && (k_q == '0);
        cur_mode    = grp_start ? mode_e'(mode) : grp_mode_q;
        cur_log2    = grp_start ? group_log2(mode_e'(mode), avg_log2, AVG_MAX_LOG2) : grp_log2_q;
        final_frame = (int'(k_q) == (1 << cur_log2) - 1);
        in_ext      = AW'(bus.in_data);
        combined    = in_ext;
        if (k_q != '0) begin
            case (cur_mode)
                MODE_PEAK: combined = (acc_rd > in_ext) ? acc_rd : in_ext;
                MODE_AVG:  combined = acc_rd + in_ext;
                default:   ;
            endcase
        end
        result = (cur_mode == MODE_AVG) ? DW'(combined >> cur_log2) : DW'(combined);
        beat   = bus.in_valid && !drop_cur;
        acc_we = beat && !final_frame;
        ram_we = beat && final_frame;
    end

    always_comb begin
        bin_d      = bin_q;
        k_d        = k_q;
        in_frame_d = in_frame_q;
        drop_d     = drop_q;
        grp_mode_d = grp_mode_q;
        grp_log2_d = grp_log2_q;
        wr_row_d   = wr_row_q;
        fill_d     = fill_q;
        row_done_d = 1'b0;
        overflow_d = overflow_q;
        if (bus.in_valid) begin
            in_frame_d = !bus.in_last;
            drop_d     = drop_cur;
            if (beat && grp_start) begin
                grp_mode_d = cur_mode;
                grp_log2_d = cur_log2;
            end
            if (bus.in_last) begin
                bin_d = '0;
                if (!drop_cur) begin
                    if (final_frame) begin
                        k_d        = '0;
                        wr_row_d   = (wr_row_q == RW'(HEIGHT - 1)) ? '0 : wr_row_q + 1'b1;
                        fill_d     = (fill_q == (RW+1)'(HEIGHT)) ? fill_q : fill_q + 1'b1;
                        row_done_d = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end else if (bin_q == BW'(BINS - 1)) begin
                overflow_d = 1'b1;
                bin_d      = '0;
            end else begin
                bin_d = bin_q + 1'b1;
            end
        end
    end

    // Read path: newest-first row index folded back into the circular buffer.
    always_comb begin
        newest = (wr_row_q == '0) ? RW'(HEIGHT - 1) : wr_row_q - 1'b1;
        if (newest >= bus.rd_row)
            row_addr = newest - bus.rd_row;
        else
            row_addr = RW'((RW+1)'(newest) + (RW+1)'(HEIGHT) - (RW+1)'(bus.rd_row));
        rd_stage_d = bus.rd_en;
        rd_addr_d  = {row_addr, bus.rd_bin};
        rd_zero_d  = ((RW+1)'(bus.rd_row) >= fill_q) || (int'(bus.rd_row) >= HEIGHT);
        rd_valid_d = rd_stage_q;
        rd_data_d  = rd_data_q;
        if (rd_stage_q) rd_data_d = rd_zero_q ? '0 : row_mem[rd_addr_q];
    end

    always_ff @(posedge clk) begin
        if (ram_we) row_mem[{wr_row_q, bin_q}] <= result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q      <= '0;
            k_q        <= '0;
            in_frame_q <= 1'b0;
            drop_q     <= 1'b0;
            grp_mode_q <= MODE_PASS;
            grp_log2_q <= '0;
            wr_row_q   <= '0;
            fill_q     <= '0;
            row_done_q <= 1'b0;
            overflow_q <= 1'b0;
            rd_stage_q <= 1'b0;
            rd_zero_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            bin_q      <= bin_d;
            k_q        <= k_d;
            in_frame_q <= in_frame_d;
            drop_q     <= drop_d;
            grp_mode_q <= grp_mode_d;
            grp_log2_q <= grp_log2_d;
            wr_row_q   <= wr_row_d;
            fill_q     <= fill_d;
            row_done_q <= row_done_d;
            overflow_q <= overflow_d;
            rd_stage_q <= rd_stage_d;
            rd_zero_q  <= rd_zero_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign row_done     = row_done_q;
    assign fill         = fill_q;
    assign overflow     = overflow_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_waterfall_accum_buffer.sv
// tb/tb_waterfall_accum_buffer.sv - directed bench with frame-level reference model
module tb_waterfall_accum_buffer;
    localparam int BINS   = 64;
    localparam int HEIGHT = 4;
    localparam int DW     = 8;
    localparam int AMAX   = 3;
    localparam int BW     = 6;
    localparam int RW     = 2;

    typedef int row_t [BINS];
    typedef struct { int due; int val; } rd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [1:0]    mode;
    logic [2:0]    avg_log2;
    logic          freeze;
    logic          row_done;
    logic [RW:0]   fill;
    logic          overflow;

    waterfall_accum_buffer_if #(.DW(DW), .BW(BW), .RW(RW)) bus ();

    waterfall_accum_buffer #(.BINS(BINS), .HEIGHT(HEIGHT), .DW(DW), .AVG_MAX_LOG2(AMAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mode     (mode),
        .avg_log2 (avg_log2),
        .freeze   (freeze),
        .row_done (row_done),
        .fill     (fill),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    row_t committed [$];
    row_t acc;
    rd_t  rdq [$];
    int   m_bin, grp_k, grp_n, grp_mode, fill_m, last_rd;
    bit   drop_m, in_frame_m, ovf_m, row_done_due;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        committed.delete();
        rdq.delete();
        fill_m = 0; ovf_m = 0; m_bin = 0; grp_k = 0; grp_n = 1; grp_mode = 0;
        in_frame_m = 0; drop_m = 0; row_done_due = 0; last_rd = 0;
    endtask

    // Frame-level reduction: collect frames of a group, commit the reduced row.
    task automatic model_beat(input int d, input bit last, input int cm, input int ca, input bit cf);
        row_t r;
        if (!in_frame_m) begin
            drop_m = cf;
            if (!drop_m && grp_k == 0) begin
                grp_mode = cm;
                grp_n = (cm == 1 || cm == 2) ? (1 << ((ca > AMAX) ? AMAX : ca)) : 1;
            end
        end
        if (!drop_m) begin
            if (grp_k == 0) acc[m_bin] = d;
            else if (grp_mode == 1) acc[m_bin] = (d > acc[m_bin]) ? d : acc[m_bin];
            else acc[m_bin] = acc[m_bin] + d;
        end
        if (last) begin
            in_frame_m = 0;
            m_bin = 0;
            if (!drop_m) begin
                if (grp_k == grp_n - 1) begin
                    for (int b = 0; b < BINS; b++) r[b] = (grp_mode == 2) ? acc[b] / grp_n : acc[b];
                    committed.push_front(r);
                    fill_m = (committed.size() > HEIGHT) ? HEIGHT : committed.size();
                    row_done_due = 1;
                    grp_k = 0;
                end else begin
                    grp_k++;
                end
            end
        end else begin
            in_frame_m = 1;
            if (m_bin == BINS - 1) begin ovf_m = 1; m_bin = 0; end
            else m_bin++;
        end
    endtask

    function automatic int data_of(input int kind, input int base, input int special, input int b);
        if (special >= 0 && b == 7) return special;
        case (kind)
            1:       return b & 255;
            2:       return (b * 2) & 255;
            default: return base;
        endcase
    endfunction

    task automatic idle(input int n);
        bus.in_valid = 0; bus.in_last = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int kind, input int base, input int special, input int nbeats,
                              input bit with_last, input int ev_at, input int ev_mode, input int ev_frz);
        int d;
        for (int i = 0; i < nbeats; i++) begin
            if (i == ev_at) begin
                if (ev_mode >= 0) mode = 2'(ev_mode);
                if (ev_frz >= 0) freeze = 1'(ev_frz);
            end
            d = data_of(kind, base, special, m_bin);
            bus.in_valid = 1;
            bus.in_data  = 8'(d);
            bus.in_last  = with_last && (i == nbeats - 1);
            @(posedge clk); #1;
            model_beat(d, bus.in_last, int'(mode), int'(avg_log2), freeze);
        end
        bus.in_valid = 0; bus.in_last = 0;
    endtask

    task automatic rd(input int row, input int bin, input int lit);
        int   e;
        rd_t  t;
        e = (row < committed.size() && row < HEIGHT) ? committed[row][bin] : 0;
        if (lit >= 0) chk("rd_model_pin", e, lit);
        bus.rd_en = 1; bus.rd_row = RW'(row); bus.rd_bin = BW'(bin);
        t.due = cyc + 2; t.val = e;
        rdq.push_back(t);
        @(posedge clk); #1;
        bus.rd_en = 0;
        idle(3);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        model_reset();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        chk("row_done", row_done, row_done_due);
        row_done_due = 0;
        chk("fill", fill, fill_m);
        chk("overflow", overflow, ovf_m);
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            chk("rd_valid_hi", bus.rd_valid, 1);
            chk("rd_data", bus.rd_data, rdq[0].val);
            last_rd = rdq[0].val;
            void'(rdq.pop_front());
        end else begin
            chk("rd_valid_lo", bus.rd_valid, 0);
            chk("rd_hold", bus.rd_data, last_rd);
        end
    end

    initial begin
        bus.in_data = 0; bus.in_valid = 0; bus.in_last = 0;
        bus.rd_en = 0; bus.rd_bin = 0; bus.rd_row = 0;
        mode = 0; avg_log2 = 0; freeze = 0;
        model_reset();
        #1 rst_n = 0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1;
        chk("rst_fill", fill, 0);
        rd(0, 0, 0);

        for (int k = 0; k < 3; k++) send_frame(1, 0, -1, BINS, 1, -1, -1, -1);
        idle(2);
        chk("pass_fill", fill, 3);
        rd(0, 5, 5);
        rd(2, 63, 63);

        do_reset();
        mode = 2; avg_log2 = 2;
        send_frame(0, 10, -1, BINS, 1, -1, -1, -1);
        send_frame(0, 20, -1, BINS, 1, -1, -1, -1);
        send_frame(0, 30, -1, BINS, 1, -1, -1, -1);
        chk("avg_fill_pre", fill, 0);
        send_frame(0, 41, -1, BINS, 1, -1, -1, -1);
        idle(2);
        chk("avg_fill", fill, 1);
        rd(0, 0, 25);
        rd(0, 63, 25);

        do_reset();
        mode = 2; avg_log2 = 7;
        for (int k = 1; k <= 8; k++) send_frame(0, k, -1, BINS, 1, -1, -1, -1);
        idle(2);
        chk("avg_clamp_fill", fill, 1);
        rd(0, 3, 4);

        do_reset();
        mode = 1; avg_log2 = 1;
        send_frame(0, 100, 200, BINS, 1, -1, -1, -1);
        send_frame(0, 120, 50, BINS, 1, 3, 0, -1);
        idle(2);
        chk("peak_fill", fill, 1);
        send_frame(2, 0, -1, BINS, 1, -1, -1, -1);
        idle(2);
        chk("peak_next_fill", fill, 2);
        rd(1, 7, 200);
        rd(1, 0, 120);
        rd(0, 7, 14);

        do_reset();
        mode = 3;
        for (int k = 1; k <= 6; k++) send_frame(0, k, -1, BINS, 1, -1, -1, -1);
        idle(2);
        chk("wrap_fill", fill, 4);
        for (int r = 0; r < 4; r++) rd(r, 9, 6 - r);

        do_reset();
        mode = 0;
        send_frame(0, 1, -1, BINS, 1, 30, -1, 1);
        send_frame(0, 2, -1, BINS, 1, 30, -1, 0);
        send_frame(0, 3, -1, BINS, 1, -1, -1, -1);
        idle(2);
        chk("freeze_fill", fill, 2);
        rd(0, 0, 3);
        rd(1, 40, 1);

        do_reset();
        mode = 0;
        send_frame(1, 0, -1, BINS + 1, 0, -1, -1, -1);
        chk("ovf_set", overflow, 1);
        send_frame(1, 0, -1, 5, 1, -1, -1, -1);
        idle(2);
        chk("ovf_sticky", overflow, 1);
        send_frame(1, 0, -1, 10, 0, -1, -1, -1);
        do_reset();
        chk("rst_ovf", overflow, 0);
        chk("rst_fill2", fill, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        send_frame(1, 0, -1, BINS, 1, -1, -1, -1);
        idle(2);
        chk("post_rst_fill", fill, 1);
        rd(0, 5, 5);
        rd(0, 63, 63);

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/waterfall_accum_buffer.md
Name: waterfall_accum_buffer

Overview:
Single-clock, parametrised spectrogram row store with a per-bin frame combiner. It sits between the log-magnitude stage and the display read-out. Groups of 2^avg_log2 input frames are reduced by pass, peak-hold or average mode and committed as one row into a circular HEIGHT-row buffer. Freeze, fill tracking and a row-committed pulse are included; reads are indexed newest-first.

Parameters:
BINS, 512, bins per frame (power of two)
HEIGHT, 300, rows retained (≤ 2^RW)
DW, 8, sample width
AVG_MAX_LOG2, 3, max avg_log2; accumulator width DW+AVG_MAX_LOG2
BW, $clog2(BINS), bin index width (derived)
RW, $clog2(HEIGHT), row index width (derived)

Ports:
clk  in  1  sole clock
rst_n  in  1  asynchronous reset, active-low
in_data  in  DW  log-magnitude sample
in_valid  in  1  sample strobe
in_last  in  1  last bin of frame (qualified by in_valid)
mode  in  2  0 pass, 1 peak, 2 average, 3 reserved (treated as pass)
avg_log2  in  3  group size exponent, clamped to AVG_MAX_LOG2
freeze  in  1  drop incoming frames
rd_en  in  1  read request
rd_bin  in  BW  read bin
rd_row  in  RW  0 = newest committed row
rd_data  out  DW  read data
rd_valid  out  1  rd_data valid
row_done  out  1  one-cycle pulse per committed row
fill  out  RW+1  committed rows, saturates at HEIGHT
overflow  out  1  sticky: beat after bin BINS-1 without in_last

Behaviour:
- Reset (async, rst_n low): bin/row/group counters 0, fill 0, rd_data 0, rd_valid 0, row_done 0, overflow 0. RAM contents not cleared; masked by fill.
- Frame start = first in_valid beat after reset or after an in_last beat. At frame start, sample freeze. If freeze = 1, discard the whole frame (no accumulation, no commit). Freeze changes mid-frame are ignored.
- At the start of the first frame of a group, latch mode and N = 2^min(avg_log2, AVG_MAX_LOG2). Pass/reserved modes force N = 1. Changes mid-group apply to the next group.
- Per beat at bin b, frame k of group:
  - k = 0: acc[b] = in_data.
  - Otherwise acc[b] = max(acc[b], in_data) in peak mode, or acc[b] + in_data in average mode.
  - Accumulator line has combinational read (LUTRAM) for same-cycle read-modify-write.
- On the final frame (k = N-1), write the result to row wr_row, bin b, in the same beat. Result is the combined value (peak) or (acc+in_data) >> log2 N, truncated (average). acc is not updated.
- Final-frame in_last beat: wr_row advances (HEIGHT-1 wraps to 0), fill increments (saturating), row_done pulses on the next cycle.
- Bin counter: increments per beat, resets on in_last. A beat at bin BINS-1 without in_last sets overflow and wraps to 0. Short frames are legal; unreceived bins keep stale data.
- Read:
  - rd_row_addr = newest - rd_row modulo HEIGHT, where newest = wr_row-1 mod HEIGHT.
  - Latency 2 cycles: registered address, then registered RAM output.
  - rd_valid = rd_en delayed 2.
  - rd_data = 0 when rd_row ≥ fill or rd_row ≥ HEIGHT.
  - rd_data holds its value when rd_valid = 0.
- Same-address write and read in the same cycle: read-first, returns old data.
- Reset mid-frame: partial group abandoned; next beat is bin 0, frame 0.

Decomposition:
- waterfall_pkg:
  - mode_e enum (MODE_PASS, MODE_PEAK, MODE_AVG)
  - clamp/width helper functions
- Sub-module waterfall_accum_line: BINS × (DW+AVG_MAX_LOG2) LUTRAM with combinational read and synchronous write.
- Row store: the existing single-clock BRAM primitive.

Test Plan:
- Pass mode, 3 frames with in_data = bin & 0xFF, in_last at bin 511 → row_done ×3, fill=3. rd_row=0, rd_bin=5 → 5 two cycles after rd_en.
- Average, avg_log2=2, frames of constant 10, 20, 30, 41 → one commit, all bins = 25, fill=1.
- Peak, avg_log2=1, bin 7 gets 200 then 50 → bin 7 = 200. Mode switched to pass mid-group → takes effect on next group only.
- HEIGHT=4 build, 6 pass frames of constant k (1..6) → fill=4. rd_row 0..3 → 6,5,4,3. rd_row=0 before any commit → 0.
- freeze high across frame 2 of 3 (set mid frame 1) → frame 1 committed, frame 2 dropped, frame 3 committed; fill=2.
- 513 beats without in_last → overflow=1 and stays set. rst_n pulse mid-frame → all outputs 0, next frame starts at bin 0.
